// File: rtl/axis_frame_fifo.sv
// Frame-aware AXI4-Stream buffer: truncates frames at the programmed length, flags short/long
// frames and keeps frame/drop statistics. Synchronous FIFO with a registered output stage.
module axis_frame_fifo #(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned DATA_W = 64
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [DATA_W-1:0]          s_axis_tdata,
    input  logic [DATA_W/8-1:0]        s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic [DATA_W/8-1:0]        m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    input  logic [31:0]                expected_beats,
    input  logic                       clr_stats,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [15:0]                frame_count,
    output logic                       short_err,
    output logic                       long_err,
    output logic [15:0]                drop_count
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned LW     = AW + 1;
    localparam int unsigned EW     = DATA_W + KEEP_W + 1;

    typedef enum logic [0:0] {StPass, StDiscard} state_e;

    state_e              state_q, state_d;
    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [KEEP_W-1:0]   out_keep_q, out_keep_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [31:0]         beat_cnt_q, beat_cnt_d;
    logic [31:0]         exp_q, exp_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                short_q, short_d;
    logic                long_q, long_d;

    logic                full, mem_empty, in_fire, out_fire, load;
    logic                wr_en, wr_last, set_short, set_long, drop_inc, at_limit;
    logic [31:0]         exp_eff;
    logic [EW-1:0]       head;

    // The level counts the output register too, so the memory is empty when only that holds data.
    assign full      = (level_q == LW'(DEPTH));
    assign mem_empty = (level_q == LW'(out_valid_q));
    assign s_axis_tready = ~sys_rst & ((state_q == StDiscard) | ~full);
    assign in_fire   = s_axis_tvalid & s_axis_tready;
    assign out_fire  = out_valid_q & m_axis_tready;
    assign load      = (~out_valid_q | m_axis_tready) & ~mem_empty;
    assign head      = mem_q[rd_ptr_q];

    // The frame length is taken from expected_beats on the first beat of each frame.
    assign exp_eff  = (beat_cnt_q == 32'd0) ? expected_beats : exp_q;
    assign at_limit = (exp_eff != 32'd0) && (beat_cnt_q == exp_eff - 32'd1);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        exp_d      = exp_q;
        wr_en      = 1'b0;
        wr_last    = s_axis_tlast;
        set_short  = 1'b0;
        set_long   = 1'b0;
        drop_inc   = 1'b0;
        if (in_fire) begin
            unique case (state_q)
                StPass: begin
                    wr_en   = 1'b1;
                    exp_d   = exp_eff;
                    wr_last = s_axis_tlast | at_limit;
                    if (at_limit && !s_axis_tlast) begin
                        set_long   = 1'b1;
                        state_d    = StDiscard;
                        beat_cnt_d = 32'd0;
                    end else if (s_axis_tlast) begin
                        set_short  = (exp_eff != 32'd0) && !at_limit;
                        beat_cnt_d = 32'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 32'd1;
                    end
                end
                StDiscard: begin
                    drop_inc = 1'b1;
                    if (s_axis_tlast) state_d = StPass;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(wr_en);
        rd_ptr_d    = rd_ptr_q + AW'(load);
        level_d     = level_q + LW'(wr_en) - LW'(out_fire);
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_keep_d  = out_keep_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_last_d  = head[EW-1];
            out_keep_d  = head[DATA_W +: KEEP_W];
            out_data_d  = head[DATA_W-1:0];
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // A clear in the same cycle as an event takes priority over the event.
    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(out_fire & out_last_q);
        drop_cnt_d  = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        short_d     = short_q | set_short;
        long_d      = long_q | set_long;
        if (clr_stats) begin
            frame_cnt_d = 16'd0;
            drop_cnt_d  = 16'd0;
            short_d     = 1'b0;
            long_d      = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {wr_last, s_axis_tkeep, s_axis_tdata};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StPass;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_keep_q  <= '0;
            out_data_q  <= '0;
            beat_cnt_q  <= '0;
            exp_q       <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_keep_q  <= out_keep_d;
            out_data_q  <= out_data_d;
            beat_cnt_q  <= beat_cnt_d;
            exp_q       <= exp_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            short_q     <= short_d;
            long_q      <= long_d;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tvalid = out_valid_q;
    assign fifo_level    = level_q;
    assign frame_count   = frame_cnt_q;
    assign drop_count    = drop_cnt_q;
    assign short_err     = short_q;
    assign long_err      = long_q;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Scoreboard bench for axis_frame_fifo: directed frames push expected beats, a monitor checks
// every output handshake and that stalled outputs hold steady.
module tb_axis_frame_fifo;

    localparam int unsigned DEPTH  = 512;
    localparam int unsigned DATA_W = 64;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [63:0] s_data = '0;
    logic [7:0]  s_keep = '0;
    logic        s_last = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_tready;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] expected_beats = '0;
    logic        clr_stats = 1'b0;
    logic [9:0]  fifo_level;
    logic [15:0] frame_count;
    logic        short_err;
    logic        long_err;
    logic [15:0] drop_count;

    axis_frame_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .s_axis_tdata   (s_data),
        .s_axis_tkeep   (s_keep),
        .s_axis_tlast   (s_last),
        .s_axis_tvalid  (s_valid),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_data),
        .m_axis_tkeep   (m_keep),
        .m_axis_tlast   (m_last),
        .m_axis_tvalid  (m_valid),
        .m_axis_tready  (m_ready),
        .expected_beats (expected_beats),
        .clr_stats      (clr_stats),
        .fifo_level     (fifo_level),
        .frame_count    (frame_count),
        .short_err      (short_err),
        .long_err       (long_err),
        .drop_count     (drop_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    rdy_rand = 1'b0;
    logic  rdy_fixed = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input int fid, input int i);
        return {16'hCAFE, 16'(fid), 32'(i)};
    endfunction

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    // Monitor: pops one expected beat per handshake; checks outputs hold while stalled.
    initial begin
        logic        stall;
        logic [63:0] pd;
        logic [7:0]  pk;
        logic        pl;
        beat_t       b;
        stall = 1'b0;
        pd = '0; pk = '0; pl = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid", 64'(m_valid), 64'd1);
                    chk("stall_data", m_data, pd);
                    chk("stall_keep", 64'(m_keep), 64'(pk));
                    chk("stall_last", 64'(m_last), 64'(pl));
                end
                if (m_valid && m_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_beat: got unexpected beat %0h, expected none", m_data);
                    end else begin
                        b = sb_q.pop_front();
                        chk("out_data", m_data, b.d);
                        chk("out_keep", 64'(m_keep), 64'(b.k));
                        chk("out_last", 64'(m_last), 64'(b.l));
                    end
                end
                stall = m_valid & ~m_ready;
                pd = m_data;
                pk = m_keep;
                pl = m_last;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input bit push, input logic exp_l);
        beat_t b;
        bit    done;
        if (push) begin
            b.d = d;
            b.k = k;
            b.l = exp_l;
            sb_q.push_back(b);
        end
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
        done    = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge sys_clk);
            if (s_tready) done = 1'b1;
            @(posedge sys_clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no s_axis_tready, expected accept of %0h", d);
        end
    endtask

    // Beats 1..n_in; the first n_out are expected out with tlast on beat n_out.
    task automatic send_frame(input int fid, input int n_in, input int n_out, input bit last_in,
                              input bit lat_chk);
        for (int i = 1; i <= n_in; i++) begin
            send_beat(beat_data(fid, i), (i == n_in) ? 8'h0F : 8'hFF, last_in && (i == n_in),
                      i <= n_out, i == n_out);
            if (lat_chk && i == 1) chk("lat_edge_n_valid", 64'(m_valid), 64'd0);
            if (lat_chk && i == 2) begin
                chk("lat_edge_n1_valid", 64'(m_valid), 64'd1);
                chk("lat_first_data", m_data, beat_data(fid, 1));
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge sys_clk);
            if (sb_q.size() == 0 && !m_valid && fifo_level == 10'd0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: got %0d beats outstanding, expected 0", name, sb_q.size());
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        idle(1);
        clr_stats = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_tready"}, 64'(s_tready), 64'd1);
        chk({tag, "_mvalid"}, 64'(m_valid), 64'd0);
        chk({tag, "_mlast"}, 64'(m_last), 64'd0);
        chk({tag, "_mdata"}, m_data, 64'd0);
        chk({tag, "_mkeep"}, 64'(m_keep), 64'd0);
        chk({tag, "_level"}, 64'(fifo_level), 64'd0);
        chk({tag, "_frames"}, 64'(frame_count), 64'd0);
        chk({tag, "_drops"}, 64'(drop_count), 64'd0);
        chk({tag, "_short"}, 64'(short_err), 64'd0);
        chk({tag, "_long"}, 64'(long_err), 64'd0);
    endtask

    initial begin
        bit got_full;

        // Power-on reset
        idle(3);
        chk("rst_tready_low", 64'(s_tready), 64'd0);
        sys_rst = 1'b0;
        #1;
        chk_reset_values("por");

        // Normal 16-beat frame with latency check
        rdy_fixed = 1'b1;
        expected_beats = 32'd16;
        idle(1);
        send_frame(1, 16, 16, 1'b1, 1'b1);
        wait_drain("normal_drain", 200);
        chk("normal_frames", 64'(frame_count), 64'd1);
        chk("normal_short", 64'(short_err), 64'd0);
        chk("normal_long", 64'(long_err), 64'd0);

        // Backpressure: 600 beats into a 512-entry FIFO with the sink stalled
        expected_beats = 32'd0;
        rdy_fixed = 1'b0;
        idle(2);
        fork
            send_frame(2, 600, 600, 1'b1, 1'b0);
            begin
                got_full = 1'b0;
                for (int i = 0; i < 3000 && !got_full; i++) begin
                    @(negedge sys_clk);
                    if (fifo_level == 10'd512) got_full = 1'b1;
                end
                repeat (5) @(negedge sys_clk);
                chk("bp_level_full", 64'(fifo_level), 64'd512);
                chk("bp_tready_low", 64'(s_tready), 64'd0);
                @(posedge sys_clk);
                #1;
                rdy_fixed = 1'b1;
            end
        join
        wait_drain("bp_drain", 3000);
        chk("bp_level_end", 64'(fifo_level), 64'd0);
        chk("bp_frames", 64'(frame_count), 64'd2);

        // Long frame truncated at 8, then a clean 8-beat frame
        pulse_clr();
        chk("clr_frames", 64'(frame_count), 64'd0);
        expected_beats = 32'd8;
        send_frame(3, 12, 8, 1'b1, 1'b0);
        wait_drain("long_drain", 200);
        chk("long_flag", 64'(long_err), 64'd1);
        chk("long_drops", 64'(drop_count), 64'd4);
        chk("long_short", 64'(short_err), 64'd0);
        chk("long_frames", 64'(frame_count), 64'd1);
        send_frame(4, 8, 8, 1'b1, 1'b0);
        wait_drain("after_long_drain", 200);
        chk("after_long_frames", 64'(frame_count), 64'd2);
        chk("after_long_drops", 64'(drop_count), 64'd4);

        // Short frame: tlast on beat 5 of 8
        pulse_clr();
        chk("clr_long", 64'(long_err), 64'd0);
        chk("clr_drops", 64'(drop_count), 64'd0);
        send_frame(5, 5, 5, 1'b1, 1'b0);
        wait_drain("short_drain", 200);
        chk("short_flag", 64'(short_err), 64'd1);
        chk("short_frames", 64'(frame_count), 64'd1);
        chk("short_long", 64'(long_err), 64'd0);

        // Random sink readiness, 20 frames of 100 beats; fills the FIFO on the way
        pulse_clr();
        expected_beats = 32'd100;
        rdy_rand = 1'b1;
        for (int f = 0; f < 20; f++) send_frame(10 + f, 100, 100, 1'b1, 1'b0);
        wait_drain("rand_drain", 6000);
        rdy_rand = 1'b0;
        rdy_fixed = 1'b1;
        chk("rand_frames", 64'(frame_count), 64'd20);
        chk("rand_short", 64'(short_err), 64'd0);
        chk("rand_long", 64'(long_err), 64'd0);

        // Reset mid-frame with 30 beats buffered
        rdy_fixed = 1'b0;
        expected_beats = 32'd0;
        idle(2);
        send_frame(40, 30, 0, 1'b0, 1'b0);
        idle(2);
        chk("mid_level", 64'(fifo_level), 64'd30);
        sys_rst = 1'b1;
        idle(2);
        chk("mid_rst_tready", 64'(s_tready), 64'd0);
        sys_rst = 1'b0;
        #1;
        chk_reset_values("mid");

        // Clear in the same cycle as a short-frame event: the clear wins
        expected_beats = 32'd8;
        send_beat(beat_data(41, 1), 8'hFF, 1'b0, 1'b1, 1'b0);
        clr_stats = 1'b1;
        send_beat(beat_data(41, 2), 8'h0F, 1'b1, 1'b1, 1'b1);
        clr_stats = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        chk("clrwin_short", 64'(short_err), 64'd0);
        chk("clrwin_frames", 64'(frame_count), 64'd0);
        rdy_fixed = 1'b1;
        wait_drain("clrwin_drain", 200);
        chk("clrwin_frames_after", 64'(frame_count), 64'd1);
        chk("clrwin_short_after", 64'(short_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
